// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_sync block.
// Optional input synchronizer is enabled with `define DEBOUNCE_SYNC_EN.
package debounce_pkg;

    // Bit 1 is the debounced level, bit 0 marks a qualification in progress.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Used by debounce_sync when DEBOUNCE_SYNC_EN is defined, and elsewhere.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw input through the flop chain; all flops clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: optional synchronizer, stability counter, 4-state FSM.
// Define DEBOUNCE_SYNC_EN to insert the SYNC_STAGES-deep synchronizer.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("debounce_sync: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("debounce_sync: DEBOUNCE_CYCLES must be >= 2");
    end

    logic w_s;

`ifdef DEBOUNCE_SYNC_EN
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (w_s)
    );
`else
    assign w_s = in;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_busy;

    // Qualify level changes on w_s; any bounce restarts from scratch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                STABLE_LO: begin
                    if (w_s) begin
                        r_state <= QUAL_HI;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                QUAL_HI: begin
                    if (!w_s) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        r_out   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!w_s) begin
                        r_state <= QUAL_LO;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                QUAL_LO: begin
                    if (w_s) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;

endmodule
